hdl_watchdog_timer: RTL

HDL-side cycle watchdog that sits directly behind the verification watchdog interface.
- Consumes the timeout count driven by the testbench watchdog through `hdl_timeout_count_`.
- Counts simulation clock ticks and raises the sticky `hdl_timeout_` flag the testbench watchdog samples.
- Instantiated once in the top-level HDL harness, next to the DUT clock generator.

---
 rtl/truss_hdl_pkg.sv | 16 +
 rtl/watchdog_prescaler.sv | 33 +++
 rtl/hdl_watchdog_timer.sv | 115 +++++++++++
 3 files changed

// File: rtl/truss_hdl_pkg.sv
// Shared types and constants for the HDL-side watchdog timer.
package truss_hdl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } wd_state_t;

    localparam int DEFAULT_COUNTER_WIDTH = 32;

    localparam int PRESCALE_MIN       = 1;
    localparam int PRESCALE_MAX       = 65535;
    localparam int PRESCALE_CNT_WIDTH = 16;

endpackage

// File: rtl/watchdog_prescaler.sv
// Tick generator for the watchdog: one tick every PRESCALE cycles while run is high.
module watchdog_prescaler
    import truss_hdl_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int P_EFF = (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN :
                           (PRESCALE > PRESCALE_MAX) ? PRESCALE_MAX : PRESCALE;
    localparam logic [PRESCALE_CNT_WIDTH-1:0] RELOAD = PRESCALE_CNT_WIDTH'(P_EFF - 1);

    // Down-counter: reload value corresponds to phase 0, terminal count 0 is the last phase.
    logic [PRESCALE_CNT_WIDTH-1:0] remain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remain <= RELOAD;
        end else if (restart || (run && remain == '0)) begin
            remain <= RELOAD;
        end else if (run) begin
            remain <= remain - PRESCALE_CNT_WIDTH'(1);
        end
    end

    assign tick = run && (remain == '0);

endmodule

// File: rtl/hdl_watchdog_timer.sv
// HDL-side cycle watchdog: counts prescaled ticks against a latched limit and raises
// a sticky timeout flag for the testbench watchdog to sample.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | not timing; elapsed=0, waiting for arm with a nonzero limit
// ARMED   | counting ticks toward the latched limit; kick restarts
// EXPIRED | limit reached; hdl_timeout sticky until clear or reset
module hdl_watchdog_timer
    import truss_hdl_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int PRESCALE      = 1,
    parameter int EXP_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] timeout_count,
    input  logic                     arm,
    input  logic                     kick,
    input  logic                     clear,
    output logic                     hdl_timeout,
    output logic [COUNTER_WIDTH-1:0] elapsed,
    output logic [1:0]               state,
    output logic                     zero_limit_err,
    output logic [EXP_WIDTH-1:0]     expirations
);

    wd_state_t                st;
    logic [COUNTER_WIDTH-1:0] limit;
    logic [COUNTER_WIDTH-1:0] elapsed_inc;
    logic                     tc_zero;
    logic                     tick;
    logic                     arm_ok;
    logic                     kick_ok;
    logic                     expire_now;
    logic                     restart;
    logic                     run;

    assign tc_zero     = (timeout_count == '0);
    assign elapsed_inc = elapsed + COUNTER_WIDTH'(1);
    assign run         = (st == ARMED);
    assign arm_ok      = (st == IDLE) && arm && !clear && !tc_zero;
    assign kick_ok     = (st == ARMED) && kick && !clear;
    assign expire_now  = (st == ARMED) && !clear && !kick && tick && (elapsed_inc == limit);
    assign restart     = clear || arm_ok || kick_ok || expire_now;

    watchdog_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st             <= IDLE;
            hdl_timeout    <= 1'b0;
            elapsed        <= '0;
            zero_limit_err <= 1'b0;
            expirations    <= '0;
            limit          <= '0;
        end else begin
            zero_limit_err <= 1'b0;
            if (clear) begin
                st          <= IDLE;
                hdl_timeout <= 1'b0;
                elapsed     <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (arm) begin
                            if (tc_zero) begin
                                zero_limit_err <= 1'b1;
                            end else begin
                                limit <= timeout_count;
                                st    <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        // A kick beats a simultaneous expiring tick.
                        if (kick) begin
                            elapsed <= '0;
                            if (tc_zero) begin
                                zero_limit_err <= 1'b1;
                            end else begin
                                limit <= timeout_count;
                            end
                        end else if (tick) begin
                            if (elapsed_inc == limit) begin
                                st          <= EXPIRED;
                                hdl_timeout <= 1'b1;
                                elapsed     <= limit;
                                if (expirations != '1) begin
                                    expirations <= expirations + EXP_WIDTH'(1);
                                end
                            end else begin
                                elapsed <= elapsed_inc;
                            end
                        end
                    end
                    EXPIRED: ;
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign state = st;

endmodule
